// File: rtl/sprite_blitter_if.sv
// Request/pixel bus between a sprite requester (master) and the blitter (slave).
interface sprite_blitter_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_colour;
    logic [1:0] req_shape;
    logic       req_erase;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_x, req_y, req_colour, req_shape, req_erase,
        input  req_ready, out_x, out_y, out_colour, plot, busy, done
    );

    modport slave (
        input  req_valid, req_x, req_y, req_colour, req_shape, req_erase,
        output req_ready, out_x, out_y, out_colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: expands one 4x4 sprite draw/erase request into per-pixel
// plot writes (row-major, one pixel per clock), clipping off-screen pixels.
module sprite_blitter #(
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
    input  logic             clock,
    input  logic             reset,
    sprite_blitter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0] X_LIMIT = SCREEN_W[8:0];
    localparam logic [7:0] Y_LIMIT = SCREEN_H[7:0];

    // Shape masks, row 0 in bits [15:12], column 0 in the MSB of each row.
    function automatic logic [15:0] shape_mask(input logic [1:0] shape);
        logic [15:0] m;
        case (shape)
            2'd0:    m = 16'b1111_1111_1111_1111;
            2'd1:    m = 16'b0110_1100_1110_0110;
            2'd2:    m = 16'b0110_1111_1111_1010;
            default: m = 16'b0000_0110_0110_0000;
        endcase
        return m;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic [1:0] shape_q, shape_d;
    logic       erase_q, erase_d;
    logic [7:0] out_x_q, out_x_d;
    logic [6:0] out_y_q, out_y_d;
    logic [2:0] out_colour_q, out_colour_d;
    logic       plot_q, plot_d;
    logic       done_q, done_d;

    // The first pixel is registered on the acceptance edge, so while idle
    // the pixel source is the live request; afterwards it is the latched copy.
    logic       in_idle;
    logic [7:0] src_x;
    logic [6:0] src_y;
    logic [2:0] src_colour;
    logic [1:0] src_shape;
    logic       src_erase;
    logic [3:0] pix_idx;

    assign in_idle    = (state_q == IDLE);
    assign src_x      = in_idle ? bus.req_x      : x_q;
    assign src_y      = in_idle ? bus.req_y      : y_q;
    assign src_colour = in_idle ? bus.req_colour : colour_q;
    assign src_shape  = in_idle ? bus.req_shape  : shape_q;
    assign src_erase  = in_idle ? bus.req_erase  : erase_q;
    assign pix_idx    = in_idle ? 4'd0 : idx_q + 4'd1;

    // Per-column x sums and per-row y sums, kept wide enough to see overflow.
    logic [8:0] col_x [4];
    logic [7:0] row_y [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_offsets
        assign col_x[gi] = {1'b0, src_x} + 9'(gi);
        assign row_y[gi] = {1'b0, src_y} + 8'(gi);
    end

    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic        pix_clipped;
    logic [15:0] pix_mask;
    logic        pix_on;

    assign pix_x       = col_x[pix_idx[1:0]];
    assign pix_y       = row_y[pix_idx[3:2]];
    assign pix_clipped = (pix_x >= X_LIMIT) || (pix_y >= Y_LIMIT);
    assign pix_mask    = shape_mask(src_shape);
    assign pix_on      = ~pix_clipped & (src_erase | pix_mask[~pix_idx]);

    // Next-state and registered-output logic for the IDLE/SCAN/DONE sequence.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        shape_d      = shape_q;
        erase_d      = erase_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_colour_d = out_colour_q;
        plot_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    x_d          = bus.req_x;
                    y_d          = bus.req_y;
                    colour_d     = bus.req_colour;
                    shape_d      = bus.req_shape;
                    erase_d      = bus.req_erase;
                    idx_d        = 4'd0;
                    out_x_d      = pix_x[7:0];
                    out_y_d      = pix_y[6:0];
                    out_colour_d = src_erase ? ERASE_COLOUR : src_colour;
                    plot_d       = pix_on;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (idx_q == 4'd15) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d        = pix_idx;
                    out_x_d      = pix_x[7:0];
                    out_y_d      = pix_y[6:0];
                    out_colour_d = src_erase ? ERASE_COLOUR : src_colour;
                    plot_d       = pix_on;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 3'd0;
            shape_q      <= 2'd0;
            erase_q      <= 1'b0;
            out_x_q      <= 8'd0;
            out_y_q      <= 7'd0;
            out_colour_q <= 3'd0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            shape_q      <= shape_d;
            erase_q      <= erase_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_colour_q <= out_colour_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
        end
    end

    assign bus.req_ready  = in_idle & ~reset;
    assign bus.busy       = ~in_idle;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_colour = out_colour_q;
    assign bus.plot       = plot_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: the driver pushes expected pixel
// writes and done pulses per request; a negedge monitor pops and compares.
module tb_sprite_blitter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sprite_blitter_if bus ();

    sprite_blitter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int at;
        int x;
        int y;
        int col;
    } pix_t;

    pix_t plot_exp[$];
    int   done_exp[$];

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int ready_cycle = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    int hold_from = 1 << 30;
    int hold_x = 0, hold_y = 0, hold_col = 0;
    int n_req = 0;
    bit mon_en = 1'b0;

    logic [15:0] mask_tbl [4] = '{16'hFFFF, 16'h6CE6, 16'h6FFA, 16'h0660};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: expand a request accepted in cycle a into its writes.
    task automatic model_accept(input int a, input int x, input int y,
                                input int col, input int shape, input bit erase);
        logic [15:0] m;
        m = mask_tbl[shape];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int  px, py;
                bit  vis, on;
                px  = x + c;
                py  = y + r;
                vis = (px < 160) && (py < 120);
                on  = erase ? vis : (vis && m[15 - (4 * r + c)]);
                if (on) plot_exp.push_back('{a + 1 + 4 * r + c, px, py, erase ? 0 : col});
            end
        end
        done_exp.push_back(a + 17);
        busy_lo     = a + 1;
        busy_hi     = a + 17;
        ready_cycle = a + 18;
        hold_from   = a + 16;
        hold_x      = (x + 3) % 256;
        hold_y      = (y + 3) % 128;
        hold_col    = erase ? 0 : col;
    endtask

    // Present a request and hold req_valid until the model says it is taken.
    task automatic issue(input int x, input int y, input int col,
                         input int shape, input bit erase);
        int guard;
        bus.req_valid  = 1'b1;
        bus.req_x      = 8'(x);
        bus.req_y      = 7'(y);
        bus.req_colour = 3'(col);
        bus.req_shape  = 2'(shape);
        bus.req_erase  = erase;
        guard = 0;
        while (cyc < ready_cycle) begin
            @(posedge clock); #1;
            guard++;
            if (guard > 100) begin
                $display("[TB] FAIL issue_timeout cycle %0d: got busy expected ready", cyc);
                $fatal(1, "issue timeout");
            end
        end
        model_accept(cyc, x, y, col, shape, erase);
        n_req++;
        $display("[TB] req %0d accepted cycle %0d x=%0d y=%0d col=%0d shape=%0d erase=%0d",
                 n_req, cyc, x, y, col, shape, erase);
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    // Assert reset in the current cycle for n cycles; pending work is discarded.
    task automatic do_reset(input int n);
        int r;
        pix_t keep[$];
        int   keep_d[$];
        r = cyc;
        reset = 1'b1;
        foreach (plot_exp[i]) if (plot_exp[i].at <= r) keep.push_back(plot_exp[i]);
        foreach (done_exp[i]) if (done_exp[i] <= r) keep_d.push_back(done_exp[i]);
        plot_exp = keep;
        done_exp = keep_d;
        if (busy_hi > r) busy_hi = r;
        hold_from = r + 1;
        hold_x = 0; hold_y = 0; hold_col = 0;
        repeat (n) begin
            @(posedge clock); #1;
        end
        reset = 1'b0;
        ready_cycle = cyc;
        $display("[TB] reset pulse cycles %0d..%0d", r, cyc - 1);
    endtask

    // Monitor: per-cycle handshake checks plus scoreboard pops on plot/done.
    always @(negedge clock) begin
        if (mon_en) begin
            bit exp_busy;
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            chk("busy", int'(bus.busy), int'(exp_busy));
            chk("req_ready", int'(bus.req_ready), int'(!reset && !exp_busy));

            while (plot_exp.size() > 0 && plot_exp[0].at < cyc) begin
                chk("missing_plot_at", cyc, plot_exp[0].at);
                void'(plot_exp.pop_front());
            end
            if (bus.plot) begin
                if (plot_exp.size() > 0 && plot_exp[0].at == cyc) begin
                    pix_t e;
                    e = plot_exp.pop_front();
                    chk("plot_x", int'(bus.out_x), e.x);
                    chk("plot_y", int'(bus.out_y), e.y);
                    chk("plot_colour", int'(bus.out_colour), e.col);
                end else begin
                    chk("unexpected_plot", 1, 0);
                end
            end

            while (done_exp.size() > 0 && done_exp[0] < cyc) begin
                chk("missing_done_at", cyc, done_exp[0]);
                void'(done_exp.pop_front());
            end
            if (bus.done) begin
                if (done_exp.size() > 0 && done_exp[0] == cyc) begin
                    void'(done_exp.pop_front());
                    chk("done", 1, 1 - int'(bus.plot));
                end else begin
                    chk("unexpected_done", 1, 0);
                end
            end

            if (cyc >= hold_from && !exp_busy) begin
                chk("hold_x", int'(bus.out_x), hold_x);
                chk("hold_y", int'(bus.out_y), hold_y);
                chk("hold_colour", int'(bus.out_colour), hold_col);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog cycle %0d: got running expected finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        bus.req_shape  = '0;
        bus.req_erase  = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_x", int'(bus.out_x), 0);
        chk("rst_out_y", int'(bus.out_y), 0);
        chk("rst_out_colour", int'(bus.out_colour), 0);
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ready", int'(bus.req_ready), 0);
        hold_from = cyc;
        mon_en = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        ready_cycle = cyc;

        // Directed cases.
        issue(10, 20, 6, 0, 1'b0);       idle(20);
        issue(40, 30, 6, 1, 1'b0);       idle(20);
        issue(50, 60, 5, 2, 1'b1);       idle(20);
        issue(158, 118, 7, 0, 1'b0);     idle(20);
        issue(255, 127, 3, 0, 1'b0);     idle(20);
        // Back-to-back: B is presented while A is still busy.
        issue(20, 10, 2, 0, 1'b0);
        issue(30, 12, 4, 2, 1'b0);       idle(20);
        // Reset during cycle 5 of a solid draw.
        issue(70, 70, 1, 0, 1'b0);
        idle(4);
        do_reset(2);
        idle(3);
        issue(80, 5, 3, 3, 1'b0);        idle(20);

        // Randomized requests, often biased toward the screen edges.
        for (int n = 0; n < 40; n++) begin
            int x, y;
            if ($urandom_range(3) == 0) begin
                x = $urandom_range(255, 150);
                y = $urandom_range(127, 110);
            end else begin
                x = $urandom_range(255);
                y = $urandom_range(127);
            end
            issue(x, y, $urandom_range(7), $urandom_range(3), 1'($urandom_range(1)));
            if ($urandom_range(2) != 0) idle($urandom_range(25));
        end
        idle(25);

        chk("leftover_plots", plot_exp.size(), 0);
        chk("leftover_dones", done_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
